keypad_scan_ctrl: RTL and testbench

//  Parametrised successor of the 4x4 matrix-key scanner: scans a ROWS x COLS keypad, debounces per frame,
//  and emits press/release events (key code + direction) through a FIFO with a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 38 +++
 rtl/kp_event_fifo.sv | 60 ++++++
 rtl/keypad_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, the event record
// layout and the key-code width rule used to size event codes.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        COMPARE = 2'd1,
        EMIT    = 2'd2
    } kp_state_t;

    localparam int KP_DEF_ROWS = 4;
    localparam int KP_DEF_COLS = 4;

    // Bits needed for a key code 0..rows*cols-1, never less than one.
    function automatic int kp_code_width(input int rows, input int cols);
        int n;
        int w;
        n = rows * cols;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < n) begin
                w = i + 1;
            end
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

    localparam int KP_DEF_KW = kp_code_width(KP_DEF_ROWS, KP_DEF_COLS);

    typedef struct packed {
        logic                 press;
        logic [KP_DEF_KW-1:0] code;
    } kp_event_t;

endpackage

// File: rtl/kp_event_fifo.sv
// Synchronous FIFO for key events. A push while full is ignored here; the
// caller detects that case and records the loss.
module kp_event_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == {(AW+1){1'b0}});
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign pop_data  = r_mem[r_rd_ptr];

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// ROWS x COLS keypad scanner: drives one column low at a time, debounces whole
// frames, and reports press/release events through a small FIFO.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int ROWS       = KP_DEF_ROWS,
    parameter int COLS       = KP_DEF_COLS,
    parameter int SCAN_DIV   = 540000,
    parameter int DEB_FRAMES = 2,
    parameter int FIFO_DEPTH = 8,
    localparam int NK        = ROWS * COLS,
    localparam int KW        = kp_code_width(ROWS, COLS)
) (
    input  logic            clk,
    input  logic            nrst,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [KW-1:0]   ev_code,
    output logic            ev_press,
    output logic [NK-1:0]   key_map,
    output logic            any_key,
    output logic            frame_tc,
    output logic            overflow
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int CIDX_W = $clog2(COLS);
    localparam int ST_W   = $clog2(DEB_FRAMES + 1);

    kp_state_t         r_state;
    logic [ROWS-1:0]   r_row_s1;
    logic [ROWS-1:0]   r_row_s2;
    logic [DIV_W-1:0]  r_div_cnt;
    logic [CIDX_W-1:0] r_col_idx;
    logic [COLS-1:0]   r_col;
    logic [NK-1:0]     r_raw;
    logic [NK-1:0]     r_prev;
    logic [NK-1:0]     r_diff;
    logic [NK-1:0]     r_key_map;
    logic              r_any_key;
    logic [ST_W-1:0]   r_stable_cnt;
    logic [KW-1:0]     r_k;
    logic              r_frame_tc;
    logic              r_overflow;

    logic [ROWS-1:0]   w_row_pressed;
    logic [NK-1:0]     w_raw_next;
    logic [CIDX_W-1:0] w_col_idx_next;
    logic [COLS-1:0]   w_col_next;
    logic [ST_W-1:0]   w_stable_next;
    logic              w_push;
    logic [KW:0]       w_push_data;
    logic [KW:0]       w_pop_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    assign w_row_pressed = ~r_row_s2;

    // Two-flop synchronizer; idle rows read high through the board pull-ups.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_row_s1 <= {ROWS{1'b1}};
            r_row_s2 <= {ROWS{1'b1}};
        end else begin
            r_row_s1 <= row;
            r_row_s2 <= r_row_s1;
        end
    end

    // Raw frame with the current column's pressed rows merged in.
    always_comb begin
        w_raw_next = r_raw;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (r_col_idx == CIDX_W'(c)) begin
                    w_raw_next[r*COLS + c] = w_row_pressed[r];
                end else begin
                    w_raw_next[r*COLS + c] = r_raw[r*COLS + c];
                end
            end
        end
    end

    // Next column index and its one-cold drive pattern.
    always_comb begin
        if (r_col_idx == CIDX_W'(COLS - 1)) begin
            w_col_idx_next = {CIDX_W{1'b0}};
        end else begin
            w_col_idx_next = r_col_idx + 1'b1;
        end
        w_col_next = ~(COLS'(1) << w_col_idx_next);
    end

    // Consecutive-identical-frame counter, saturating at the debounce target.
    always_comb begin
        if (r_raw == r_prev) begin
            if (r_stable_cnt == ST_W'(DEB_FRAMES)) begin
                w_stable_next = r_stable_cnt;
            end else begin
                w_stable_next = r_stable_cnt + 1'b1;
            end
        end else begin
            w_stable_next = ST_W'(1);
        end
    end

    assign w_push      = (r_state == EMIT) && r_diff[r_k];
    assign w_push_data = {r_key_map[r_k], r_k};

    // Scan / debounce / emit sequencer; divider and column freeze outside SCAN.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state      <= SCAN;
            r_div_cnt    <= {DIV_W{1'b0}};
            r_col_idx    <= {CIDX_W{1'b0}};
            r_col        <= ~COLS'(1);
            r_raw        <= {NK{1'b0}};
            r_prev       <= {NK{1'b0}};
            r_diff       <= {NK{1'b0}};
            r_key_map    <= {NK{1'b0}};
            r_any_key    <= 1'b0;
            r_stable_cnt <= {ST_W{1'b0}};
            r_k          <= {KW{1'b0}};
            r_frame_tc   <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_tc <= 1'b0;
            if (w_push && w_fifo_full) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                SCAN: begin
                    if (r_div_cnt == DIV_W'(SCAN_DIV - 1)) begin
                        r_div_cnt <= {DIV_W{1'b0}};
                        r_raw     <= w_raw_next;
                        r_col_idx <= w_col_idx_next;
                        r_col     <= w_col_next;
                        if (r_col_idx == CIDX_W'(COLS - 1)) begin
                            r_frame_tc <= 1'b1;
                            r_state    <= COMPARE;
                        end else begin
                            r_state <= SCAN;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                COMPARE: begin
                    r_stable_cnt <= w_stable_next;
                    r_prev       <= r_raw;
                    if ((w_stable_next == ST_W'(DEB_FRAMES)) && (r_raw != r_key_map)) begin
                        r_diff    <= r_raw ^ r_key_map;
                        r_key_map <= r_raw;
                        r_any_key <= |r_raw;
                        r_k       <= {KW{1'b0}};
                        r_state   <= EMIT;
                    end else begin
                        r_state <= SCAN;
                    end
                end
                EMIT: begin
                    if (r_k == KW'(NK - 1)) begin
                        r_state <= SCAN;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: begin
                    r_state <= SCAN;
                end
            endcase
        end
    end

    kp_event_fifo #(
        .WIDTH (KW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (ev_ready),
        .pop_data  (w_pop_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    assign col      = r_col;
    assign ev_valid = !w_fifo_empty;
    assign ev_press = w_pop_data[KW];
    assign ev_code  = w_pop_data[KW-1:0];
    assign key_map  = r_key_map;
    assign any_key  = r_any_key;
    assign frame_tc = r_frame_tc;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad model drives the rows, a
// map-diff reference predicts events, and a monitor checks each handshake.
module tb_keypad_scan_ctrl;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        ev_valid;
    logic        ev_ready = 1'b1;
    logic [3:0]  ev_code;
    logic        ev_press;
    logic [15:0] key_map;
    logic        any_key;
    logic        frame_tc;
    logic        overflow;

    logic [15:0] keys = 16'h0000;
    logic [15:0] acc_map = 16'h0000;
    logic        exp_ovf = 1'b0;
    int          ready_mode = 1;
    logic [4:0]  exp_q [$];
    int          n_pass = 0;
    int          n_total = 0;

    keypad_scan_ctrl #(
        .ROWS       (4),
        .COLS       (4),
        .SCAN_DIV   (8),
        .DEB_FRAMES (2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk      (clk),
        .nrst     (nrst),
        .row      (row),
        .col      (col),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_code  (ev_code),
        .ev_press (ev_press),
        .key_map  (key_map),
        .any_key  (any_key),
        .frame_tc (frame_tc),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low while its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (!col[c] && keys[r*4 + c]) row[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Consumer: 0 = stalled, 1 = always ready, 2 = random back-pressure.
    always begin
        @(posedge clk);
        #1;
        if (ready_mode == 0) ev_ready = 1'b0;
        else if (ready_mode == 1) ev_ready = 1'b1;
        else ev_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: compares every presented event against the scoreboard head.
    always @(negedge clk) begin
        if (nrst && ev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_event", {27'd0, ev_press, ev_code}, 32'hFFFF_FFFF);
            end else if (ev_ready) begin
                chk("event", {27'd0, ev_press, ev_code}, {27'd0, exp_q.pop_front()});
            end else begin
                chk("stall_head", {27'd0, ev_press, ev_code}, {27'd0, exp_q[0]});
            end
        end
    end

    // Reference: events are the ascending-code diff between accepted maps.
    task automatic apply_map(input logic [15:0] m, input int hold);
        for (int k = 0; k < 16; k++) begin
            if (m[k] != acc_map[k]) begin
                if (ready_mode == 0 && exp_q.size() >= 4) exp_ovf = 1'b1;
                else exp_q.push_back({m[k], 4'(k)});
            end
        end
        acc_map = m;
        keys = m;
        repeat (hold) @(posedge clk);
        #1;
        chk("key_map", {16'd0, key_map}, {16'd0, acc_map});
        chk("any_key", {31'd0, any_key}, {31'd0, |acc_map});
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] m;
        logic        got;
        int          hold;
        hold = 250;

        // Reset state and column / frame timing.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_col", {28'd0, col}, {28'd0, 4'b1110});
        chk("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("rst_key_map", {16'd0, key_map}, 32'd0);
        chk("rst_any_key", {31'd0, any_key}, 32'd0);
        chk("rst_frame_tc", {31'd0, frame_tc}, 32'd0);
        chk("rst_overflow", {31'd0, overflow}, 32'd0);
        nrst = 1'b1;
        for (int c = 1; c <= 66; c++) begin
            @(posedge clk);
            #1;
            if (c == 7)  chk("col_c7",  {28'd0, col}, {28'd0, 4'b1110});
            if (c == 8)  chk("col_c8",  {28'd0, col}, {28'd0, 4'b1101});
            if (c == 16) chk("col_c16", {28'd0, col}, {28'd0, 4'b1011});
            if (c == 24) chk("col_c24", {28'd0, col}, {28'd0, 4'b0111});
            if (c == 31) chk("tc_c31", {31'd0, frame_tc}, 32'd0);
            if (c == 32) chk("col_c32", {28'd0, col}, {28'd0, 4'b1110});
            if (c == 32) chk("tc_c32", {31'd0, frame_tc}, 32'd1);
            if (c == 33) chk("tc_c33", {31'd0, frame_tc}, 32'd0);
            if (c == 40) chk("col_c40", {28'd0, col}, {28'd0, 4'b1110});
            if (c == 41) chk("col_c41", {28'd0, col}, {28'd0, 4'b1101});
            if (c == 64) chk("tc_c64", {31'd0, frame_tc}, 32'd0);
            if (c == 65) chk("tc_c65", {31'd0, frame_tc}, 32'd1);
        end

        // Single key row2/col1 press then release.
        apply_map(16'h0200, hold);
        apply_map(16'h0000, hold);

        // One-frame bounce must not be accepted.
        keys = 16'h0010;
        repeat (20) @(posedge clk);
        keys = 16'h0000;
        repeat (hold) @(posedge clk);
        #1;
        chk("bounce_key_map", {16'd0, key_map}, 32'd0);

        // Simultaneous presses reported in ascending code order.
        apply_map(16'h1009, hold);
        apply_map(16'h0000, hold);
        drain(300);

        // Stalled consumer: fifth event is dropped, order preserved on drain.
        ready_mode = 0;
        repeat (3) @(posedge clk);
        m = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            m[5 + i] = 1'b1;
            apply_map(m, hold);
        end
        ready_mode = 1;
        drain(300);
        apply_map(16'h0000, hold);
        drain(300);

        // Reset in the middle of an emission with two events queued.
        ready_mode = 0;
        repeat (3) @(posedge clk);
        exp_q.push_back({1'b1, 4'd0});
        exp_q.push_back({1'b1, 4'd1});
        keys = 16'h0003;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            if (ev_valid) got = 1'b1;
        end
        chk("t6_valid_seen", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        keys = 16'h0000;
        acc_map = 16'h0000;
        exp_ovf = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("t6_ev_valid", {31'd0, ev_valid}, 32'd0);
        chk("t6_key_map", {16'd0, key_map}, 32'd0);
        chk("t6_col", {28'd0, col}, {28'd0, 4'b1110});
        chk("t6_overflow", {31'd0, overflow}, 32'd0);
        nrst = 1'b1;
        ready_mode = 1;
        repeat (hold) @(posedge clk);
        #1;
        chk("t6_quiet", {31'd0, ev_valid}, 32'd0);

        // Random maps with up to four flips per step under random back-pressure.
        ready_mode = 2;
        for (int s = 0; s < 20; s++) begin
            m = acc_map;
            for (int j = 0; j < 4; j++) begin
                if ($urandom_range(0, 1) == 1) m[$urandom_range(0, 15)] ^= 1'b1;
            end
            apply_map(m, hold);
        end
        ready_mode = 1;
        drain(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
